// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display path: blank patterns, digit
// count, the hex-to-segment table (active-low {g,f,e,d,c,b,a}) and a helper
// for leading-zero suppression.
package seg7_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [3:0] AN_OFF     = 4'hF;

  // Entry n is the active-low pattern for hex digit n (listed F down to 0).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  // Bit i is 1 when digit i should be shown under leading-zero suppression:
  // some nibble at or above i is non-zero, or i is the rightmost digit.
  function automatic logic [3:0] lead_zero_mask(input logic [15:0] v);
    logic [3:0] m;
    logic       seen;
    m    = '0;
    seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      seen = seen | (v[i*4 +: 4] != 4'h0);
      m[i] = seen | (i == 0);
    end
    return m;
  endfunction

endpackage

// File: rtl/bin4_to_7seg.sv
// Team hex decoder: 4-bit nibble to active-low segments {g,f,e,d,c,b,a}.
// Purely combinational; callers register the result.
module bin4_to_7seg
  import seg7_pkg::*;
(
  input  logic [3:0] bin,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern for the nibble.
  assign seg = HEX_SEG[bin];

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// One digit per REFRESH_DIV-cycle slot, the first BLANK_CYC cycles of each
// slot dark for anti-ghosting. The value is double-buffered: upd fills a
// pending register and the shadow only changes at the frame wrap, so a frame
// never tears. Define SEG7_LEADING_ZERO_BLANK_EN to suppress leading zeros.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_CYC   = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        upd,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int unsigned    DW        = $clog2(REFRESH_DIV);
  localparam logic [DW-1:0]  DIV_MAX   = DW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0]  BLANK_LIM = DW'(BLANK_CYC);

  logic [DW-1:0] div;
  logic [1:0]    idx;
  logic          tick;
  logic          wrap;
  logic          wrap_q;

  logic [15:0]   shadow;
  logic [3:0]    shadow_dp;
  logic [15:0]   pend;
  logic [3:0]    pend_dp;
  logic          pend_flag;

  logic [6:0]    seg_dec;
  logic [3:0]    show;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;

  assign tick = (div == DIV_MAX);
  assign wrap = tick & (idx == 2'd3);

  // Slot divider and digit index; wrap_q marks the first cycle of a new frame.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div    <= '0;
      idx    <= 2'd0;
      wrap_q <= 1'b0;
    end else begin
      div    <= tick ? '0 : div + DW'(1);
      idx    <= tick ? idx + 2'd1 : idx;
      wrap_q <= wrap;
    end
  end

  // Double-buffered update: pending collects upd, shadow loads only at wrap.
  // An upd on the wrap cycle goes straight to shadow with no frame of delay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend      <= '0;
      pend_dp   <= '0;
      pend_flag <= 1'b0;
      shadow    <= '0;
      shadow_dp <= '0;
    end else begin
      if (upd) begin
        pend    <= value;
        pend_dp <= dp_in;
      end
      if (wrap && upd) begin
        shadow    <= value;
        shadow_dp <= dp_in;
        pend_flag <= 1'b0;
      end else if (wrap && pend_flag) begin
        shadow    <= pend;
        shadow_dp <= pend_dp;
        pend_flag <= 1'b0;
      end else if (upd) begin
        pend_flag <= 1'b1;
      end
    end
  end

  bin4_to_7seg u_dec (
    .bin (shadow[{idx, 2'b00} +: 4]),
    .seg (seg_dec)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  assign show = digit_en & lead_zero_mask(shadow);
`else
  assign show = digit_en;
`endif

  // Next pin values from the current slot position and shadow contents.
  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    an_nxt  = AN_OFF;
    seg_nxt = SEG_BLANK;
    dp_nxt  = 1'b1;
    if (div >= BLANK_LIM) begin
      if (show[idx]) an_nxt = ~(4'b0001 << idx);
      seg_nxt = seg_dec;
      dp_nxt  = ~shadow_dp[idx];
    end
  end

  // Registered pins; reset blanks the display asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an          <= AN_OFF;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      an          <= an_nxt;
      seg         <= seg_nxt;
      dp          <= dp_nxt;
      frame_start <= wrap_q;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux with REFRESH_DIV=8, BLANK_CYC=2.
// The reference model works from elapsed cycles since reset: slot position,
// frame number and the displayed value follow from plain arithmetic on that
// count. Honours SEG7_LEADING_ZERO_BLANK_EN when the bench is built with it.
module tb_seg7_scan_mux;

  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 4 * RD;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        upd;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference patterns for hex digits 0..F, active-low {g,f,e,d,c,b,a}.
  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state: edges since reset release, displayed and pending values.
  int          cnt;
  logic [15:0] m_shadow;
  logic [3:0]  m_sdp;
  logic [15:0] m_pend;
  logic [3:0]  m_pdp;
  logic        m_flag;

  always #5 clk = ~clk;

  seg7_scan_mux #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
    .clk         (clk),
    .rst         (rst),
    .value       (value),
    .upd         (upd),
    .dp_in       (dp_in),
    .digit_en    (digit_en),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cnt);
    end
  endtask

  // Digits that should light for a given displayed value and enable mask.
  function automatic logic [3:0] vis_mask(input logic [15:0] sh, input logic [3:0] en);
    logic [3:0] m;
    m = en;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    for (int d = 3; d >= 1; d--)
      if ((sh >> (4 * d)) == 16'h0) m[d] = 1'b0;
`endif
    return m;
  endfunction

  task automatic model_reset();
    cnt      = 0;
    m_shadow = 16'h0;
    m_sdp    = 4'h0;
    m_pend   = 16'h0;
    m_pdp    = 4'h0;
    m_flag   = 1'b0;
  endtask

  // One clock: predict the pins from the state reached cnt edges after
  // reset, advance the model with this edge's inputs, then compare.
  task automatic step();
    int         d, i;
    logic [3:0] m, e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_fs;
    @(posedge clk);
    d = cnt % RD;
    i = (cnt / RD) % 4;
    m = vis_mask(m_shadow, digit_en);
    if (d < BC) begin
      e_an  = 4'hF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
    end else begin
      e_an  = m[i] ? ~(4'b0001 << i) : 4'hF;
      e_seg = hex_tab[m_shadow[4*i +: 4]];
      e_dp  = ~m_sdp[i];
    end
    e_fs = (cnt > 0) && (cnt % FRAME == 0);
    if (upd) begin
      m_pend = value;
      m_pdp  = dp_in;
      m_flag = 1'b1;
    end
    if ((cnt % FRAME == FRAME - 1) && m_flag) begin
      m_shadow = m_pend;
      m_sdp    = m_pdp;
      m_flag   = 1'b0;
    end
    cnt++;
    #1;
    check("an",          {3'b0, an},          {3'b0, e_an});
    check("seg",         seg,                 e_seg);
    check("dp",          {6'b0, dp},          {6'b0, e_dp});
    check("frame_start", {6'b0, frame_start}, {6'b0, e_fs});
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic run_to(input int phase);
    while (cnt % FRAME != phase) step();
  endtask

  task automatic strobe(input logic [15:0] v, input logic [3:0] p);
    value = v;
    dp_in = p;
    upd   = 1'b1;
    step();
    upd   = 1'b0;
  endtask

  task automatic check_blank(input string tag);
    check({tag, "_an"},  {3'b0, an},          7'h0F);
    check({tag, "_seg"}, seg,                 7'h7F);
    check({tag, "_dp"},  {6'b0, dp},          7'h01);
    check({tag, "_fs"},  {6'b0, frame_start}, 7'h00);
  endtask

  initial begin
    rst      = 1'b1;
    value    = 16'h0;
    upd      = 1'b0;
    dp_in    = 4'h0;
    digit_en = 4'hF;
    model_reset();
    #12;
    check_blank("reset");
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset: 0000 on all digits, frame_start every 32 cycles.
    run(70);

    // Mid-frame update shows only after the next wrap.
    run_to(10);
    strobe(16'h12AF, 4'b0100);
    run(70);

    // Two updates in one frame: only the last is displayed.
    run_to(3);
    strobe(16'h1111, 4'b0001);
    run(5);
    strobe(16'h2222, 4'b1000);
    run(70);

    // Update on the wrap-tick cycle goes straight to the next frame.
    run_to(FRAME - 1);
    strobe(16'h3333, 4'b0010);
    run(70);

    // Partial digit enable: digits 1 and 3 stay dark, timing unchanged.
    digit_en = 4'b0101;
    run(70);
    digit_en = 4'hF;

    // Value with leading zeros.
    strobe(16'h0050, 4'b0000);
    run(70);

    // Randomized updates and live digit enables.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 15) == 0) digit_en = 4'($urandom);
      if ($urandom_range(0, 9) == 0) strobe(16'($urandom), 4'($urandom));
      else step();
    end

    // Reset mid-slot during an active digit window.
    digit_en = 4'hF;
    strobe(16'h9876, 4'b1111);
    run(FRAME + 5);
    while (cnt % RD != 5) step();
    #2;
    rst = 1'b1;
    #1;
    check_blank("midrst");
    @(posedge clk);
    #1;
    check_blank("midrst_hold");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run(70);

    // Leading-zero value again after reset, then random tail.
    strobe(16'h0050, 4'b0010);
    run(70);
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 7) == 0) strobe(16'($urandom_range(0, 255)), 4'($urandom));
      else step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
